// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU load/store unit
// and the CNN burst engine. The CPU wins whenever the port is idle. A CNN burst
// is expanded into consecutive word addresses, and the CPU can steal one slot
// after MAX_HOLD consecutive beats have made it wait.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int BURST_W    = 4,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // CPU load/store port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_funct3,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_gnt,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_rvalid,
  // CNN burst port
  input  logic                  cnn_req,
  input  logic                  cnn_we,
  input  logic [DM_ADDRESS-1:0] cnn_base,
  input  logic [BURST_W-1:0]    cnn_len,
  output logic                  cnn_ack,
  input  logic [DATA_W-1:0]     cnn_wdata,
  output logic                  cnn_wready,
  output logic [DATA_W-1:0]     cnn_rdata,
  output logic                  cnn_rvalid,
  output logic                  cnn_done,
  // Data memory side
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [BURST_W:0]   IDX_ONE    = (BURST_W+1)'(1);
  localparam logic [2:0]         F3_WORD    = 3'b010;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]            state;
  logic [DM_ADDRESS-1:0] base_q;
  logic [BURST_W-1:0]    len_q;
  logic                  we_q;
  logic [BURST_W:0]      idx_q;
  logic [HOLD_W-1:0]     hold_q;

  logic                  cpu_grant;
  logic                  cnn_accept;
  logic                  cnn_beat;
  logic                  last_beat;
  logic [DM_ADDRESS-1:0] beat_addr;

  // Address arithmetic is modulo the memory size, so bursts wrap past the top.
  assign beat_addr = base_q + DM_ADDRESS'(idx_q);
  assign last_beat = cnn_beat && (idx_q == {1'b0, len_q});

  // Decide who owns the memory port this cycle; nothing is granted in reset.
  always_comb begin
    cpu_grant  = 1'b0;
    cnn_accept = 1'b0;
    cnn_beat   = 1'b0;
    if (rst_n) begin
      if (state == IDLE) begin
        if (cpu_req) begin
          cpu_grant = 1'b1;
        end else if (cnn_req) begin
          cnn_accept = 1'b1;
        end
      end else if (cpu_req && (hold_q == HOLD_LIMIT)) begin
        cpu_grant = 1'b1;
      end else begin
        cnn_beat = 1'b1;
      end
    end
  end

  // Drive the memory from whichever requester holds the port, zeros otherwise.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    mem_funct3 = '0;
    if (cpu_grant) begin
      mem_read   = !cpu_we;
      mem_write  = cpu_we;
      mem_addr   = cpu_addr;
      mem_wd     = cpu_wdata;
      mem_funct3 = cpu_funct3;
    end else if (cnn_beat) begin
      mem_addr   = beat_addr;
      mem_funct3 = F3_WORD;
      if (we_q) begin
        mem_write = 1'b1;
        mem_wd    = cnn_wdata;
      end else begin
        mem_read  = 1'b1;
      end
    end
  end

  assign cpu_gnt    = cpu_grant;
  assign cnn_ack    = cnn_accept;
  assign cnn_wready = cnn_beat && we_q;

  // Burst sequencer: latch the burst on ack, step beats, count CPU wait beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      len_q  <= '0;
      we_q   <= 1'b0;
      idx_q  <= '0;
      hold_q <= '0;
    end else if (cnn_accept) begin
      state  <= BURST;
      base_q <= cnn_base;
      len_q  <= cnn_len;
      we_q   <= cnn_we;
      idx_q  <= '0;
      hold_q <= '0;
    end else if (state == BURST) begin
      if (cnn_beat) begin
        idx_q  <= idx_q + IDX_ONE;
        hold_q <= cpu_req ? hold_q + HOLD_ONE : '0;
        if (last_beat) begin
          state <= IDLE;
        end
      end else begin
        // CPU took this slot; its wait is over.
        hold_q <= '0;
      end
    end
  end

  // Register read data and completion flags for both requesters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      cnn_rdata  <= '0;
      cnn_rvalid <= 1'b0;
      cnn_done   <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_grant && !cpu_we;
      if (cpu_grant && !cpu_we) begin
        cpu_rdata <= mem_rd;
      end
      cnn_rvalid <= cnn_beat && !we_q;
      if (cnn_beat && !we_q) begin
        cnn_rdata <= mem_rd;
      end
      cnn_done <= last_beat;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port arbiter and burst sequencer that shares the data memory between the RISC-V core's load/store port and the CNN engine. It sits directly in front of the data memory: it owns the memory's read/write enables, address, write data and funct3, and it drives them from whichever requester holds the port in a given cycle. CPU accesses are single-cycle and may use any load/store width. CNN accesses are word bursts that the arbiter expands into consecutive addresses, with a hold limit so the CPU is never starved during a long burst.

## Interface
- DM_ADDRESS, 9, data memory word-address width
- DATA_W, 32, data width
- BURST_W, 4, width of burst length field (beats = cnn_len+1, 1..2^BURST_W)
- MAX_HOLD, 4, max consecutive CNN beats while CPU waits (≥1)

Ports:
- clk  in  1  clock; single clock domain, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = store, 0 = load
- cpu_funct3  in  3  load/store width code, passed to memory
- cpu_addr  in  DM_ADDRESS  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  access performed this cycle
- cpu_rdata  out  DATA_W  registered load data
- cpu_rvalid  out  1  cpu_rdata valid (1 cycle after read grant)
- cnn_req  in  1  burst request, held until cnn_ack
- cnn_we  in  1  burst direction, 1 = write
- cnn_base  in  DM_ADDRESS  burst start address
- cnn_len  in  BURST_W  beats minus one
- cnn_ack  out  1  burst accepted (parameters latched)
- cnn_wdata  in  DATA_W  write beat data
- cnn_wready  out  1  write beat consumed this cycle
- cnn_rdata  out  DATA_W  registered read beat data
- cnn_rvalid  out  1  cnn_rdata valid
- cnn_done  out  1  one-cycle pulse after final beat
- mem_read, mem_write  out  1 each  memory enables
- mem_addr  out  DM_ADDRESS; mem_wd  out  DATA_W; mem_funct3  out  3
- mem_rd  in  DATA_W  combinational memory read data

## Operation
- FSM states: IDLE and BURST. Latched state: burst base, length, direction, beat index (BURST_W+1 bits), hold counter.
- IDLE:
  - If cpu_req is high, the CPU is granted (CPU has priority in IDLE).
  - Otherwise, if cnn_req is high, assert cnn_ack, latch base/len/we, clear the beat index and hold counter, and go to BURST. No memory access occurs in the ack cycle.
- BURST, each cycle:
  - If cpu_req=1 and hold==MAX_HOLD: CPU slot. Assert cpu_gnt and clear hold. The beat index does not advance and cnn_wready=0.
  - Otherwise: CNN beat at mem_addr = base+index, modulo 2^DM_ADDRESS (wraps). mem_funct3=3'b010.
    - A write beat asserts cnn_wready and drives mem_wd=cnn_wdata.
    - A read beat captures mem_rd.
    - Advance the index. Hold increments if cpu_req=1, else clears.
  - After the beat where index==len, return to IDLE.
- CPU grant: drive mem_read=!cpu_we or mem_write=cpu_we, mem_addr=cpu_addr, mem_wd=cpu_wdata, mem_funct3=cpu_funct3.
- Granted reads: mem_rd is registered into cpu_rdata (or cnn_rdata); the matching rvalid is high for exactly the following cycle.
- No grant in a cycle: mem_read=mem_write=0, mem_addr/mem_wd/mem_funct3 = 0.
- Memory outputs and grants are combinational from state and requests. rdata, rvalid, ack-side state and done are registered.
- cnn_req is only sampled in IDLE. A new burst cannot start in the cycle BURST exits.

## Timing
- Reset (asynchronous, any state, including mid-burst):
  - FSM returns to IDLE; all counters clear.
  - All outputs are 0, including rdata registers.
  - The abandoned burst produces no cnn_done.
- CPU latency:
  - Grant in the same cycle as cpu_req when the port is free.
  - A store commits on that edge.
  - Load data arrives 1 cycle after grant.
- Worst-case CPU wait during a burst: MAX_HOLD beats, granted on cycle MAX_HOLD+1.
- Burst duration: 1 ack cycle + (len+1) beats + number of CPU slots.
- cnn_done pulses in the cycle after the final beat, coincident with the last cnn_rvalid for read bursts.
- cnn_ack and cpu_gnt are never both high. At most one of mem_read/mem_write is high per cycle.

## Test plan
- CPU SW: addr 0x005, wdata 0xDEADBEEF, funct3 010; then LW 0x005. Required: cpu_gnt in the same cycle as each request; cpu_rvalid one cycle after the load grant with cpu_rdata=0xDEADBEEF. Also LB of 0x80 returns 0xFFFFFF80.
- CNN read burst: base 0x010, len 3, memory preloaded with 0x10..0x13 at those addresses. Required: ack, then mem_addr 0x010..0x013 on 4 consecutive cycles; cnn_rvalid ×4 with data 0x10..0x13; cnn_done coincident with the 4th rvalid.
- Contention: CNN write burst len 15 with MAX_HOLD=4, and cpu_req (LW) held from the first beat. Required: 4 CNN beats, then cpu_gnt with wready=0, then the remaining 12 beats; all 16 words written correctly; done 18 cycles after ack.
- Simultaneous cpu_req and cnn_req in IDLE. Required: CPU granted first; cnn_ack the next cycle.
- Wrap: base 0x1FE, len 3. Required: mem_addr sequence 0x1FE, 0x1FF, 0x000, 0x001.
- Reset pulse after beat 2 of a len-7 burst. Required: all outputs 0 immediately; no cnn_done; FSM is in IDLE and a new cnn_req is acked.
